// File: rtl/uart_rx_ctrl_fsm_pkg.sv
// Shared encodings and constants for the UART receive controller.
package uart_rx_ctrl_fsm_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    // Unsupported oversampling ratios fall back to 8.
    function automatic logic [5:0] prescale_norm(input logic [5:0] p);
        case (p)
            PRESCALE_16: return PRESCALE_16;
            PRESCALE_32: return PRESCALE_32;
            default:     return PRESCALE_8;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_fsm_edge_bit_cnt.sv
// Oversample edge counter with a bit counter that advances on each edge wrap.
module uart_rx_edge_bit_cnt
    import uart_rx_ctrl_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_enable,
    input  logic       i_clear,
    input  logic [5:0] i_prescale,
    output logic [5:0] o_edge_cnt,
    output logic [3:0] o_bit_cnt,
    output logic       o_last
);

    logic [5:0] r_edge_cnt;
    logic [3:0] r_bit_cnt;
    logic       w_last;

    assign w_last = (r_edge_cnt == (i_prescale - 6'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (i_clear) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (i_enable) begin
            if (w_last) begin
                r_edge_cnt <= '0;
                r_bit_cnt  <= r_bit_cnt + 4'd1;
            end else begin
                r_edge_cnt <= r_edge_cnt + 6'd1;
            end
        end
    end

    assign o_edge_cnt = r_edge_cnt;
    assign o_bit_cnt  = r_bit_cnt;
    assign o_last     = w_last;

endmodule

// File: rtl/uart_rx_ctrl_fsm.sv
// UART receive controller: frame sequencing FSM and strobe decode.
//   state  | meaning
//   IDLE   | line idle, waiting for rx_in low
//   START  | timing start bit, glitch check at mid-bit
//   DATA   | shifting DATA_WIDTH data bits
//   PARITY | timing parity bit
//   STOP   | timing stop bit, frame verdict at its end
module uart_rx_ctrl_fsm
    import uart_rx_ctrl_fsm_pkg::*;
#(
    parameter int DATA_WIDTH = uart_rx_ctrl_fsm_pkg::DATA_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx_in,
    input  logic [5:0] i_prescale,
    input  logic       i_par_en,
    input  logic       i_start_glitch,
    input  logic       i_par_err,
    input  logic       i_stop_err,
    output logic       o_data_samp_en,
    output logic       o_start_check_en,
    output logic       o_par_check_en,
    output logic       o_stop_check_en,
    output logic       o_deser_en,
    output logic [5:0] o_edge_cnt,
    output logic [3:0] o_bit_cnt,
    output logic       o_data_valid,
    output logic       o_busy
);

    localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [5:0] r_prescale;
    logic       r_par_en;
    logic       r_data_valid;
    logic       w_last;
    logic       w_clear;
    logic       w_go_start;
    logic       w_data_done;
    logic       w_at_half;
    logic [5:0] w_edge_cnt;
    logic [3:0] w_bit_cnt;

    uart_rx_edge_bit_cnt u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_enable   (o_busy),
        .i_clear    (w_clear),
        .i_prescale (r_prescale),
        .o_edge_cnt (w_edge_cnt),
        .o_bit_cnt  (w_bit_cnt),
        .o_last     (w_last)
    );

    assign w_data_done = (r_state == ST_DATA) && w_last && (w_bit_cnt == LAST_DATA_BIT);
    assign w_go_start  = !i_rx_in && ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_last));
    // Counters restart on every frame boundary and on a rejected start bit.
    assign w_clear     = (r_state == ST_IDLE) ||
                         (w_last && (((r_state == ST_START) && i_start_glitch) || (r_state == ST_STOP)));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (!i_rx_in) w_state_nxt = ST_START;
            ST_START:  if (w_last) w_state_nxt = i_start_glitch ? ST_IDLE : ST_DATA;
            ST_DATA:   if (w_data_done) w_state_nxt = i_par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: if (w_last) w_state_nxt = ST_STOP;
            ST_STOP:   if (w_last) w_state_nxt = i_rx_in ? ST_IDLE : ST_START;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_prescale   <= PRESCALE_8;
            r_par_en     <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_data_valid <= (r_state == ST_STOP) && w_last && !i_stop_err &&
                            (!r_par_en || !i_par_err);
            if (w_go_start)  r_prescale <= prescale_norm(i_prescale);
            if (w_data_done) r_par_en   <= i_par_en;
        end
    end

    assign w_at_half        = (w_edge_cnt == ((r_prescale >> 1) + 6'd2));
    assign o_busy           = (r_state != ST_IDLE);
    assign o_data_samp_en   = o_busy;
    assign o_start_check_en = (r_state == ST_START)  && w_at_half;
    assign o_deser_en       = (r_state == ST_DATA)   && w_at_half;
    assign o_par_check_en   = (r_state == ST_PARITY) && w_at_half;
    assign o_stop_check_en  = (r_state == ST_STOP)   && w_at_half;
    assign o_edge_cnt       = w_edge_cnt;
    assign o_bit_cnt        = w_bit_cnt;
    assign o_data_valid     = r_data_valid;

endmodule

// File: doc/uart_rx_ctrl_fsm.md
UART_RX_CTRL_FSM -- requirements
Module: uart_rx_ctrl_fsm

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 clk  input  1  receive oversampling clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 rx_in  input  1  serial line, already synchronised; idle high.
REQ-005 prescale  input  6  oversampling ratio; legal values are 8, 16 and 32.
REQ-006 par_en  input  1  1 = the frame carries a parity bit.
REQ-007 start_glitch  input  1  registered result from the start checker; 1 = false start.
REQ-008 par_err  input  1  registered result from the parity checker.
REQ-009 stop_err  input  1  registered result from the stop checker.
REQ-010 data_samp_en  output  1  enables the data sampler.
REQ-011 start_check_en, par_check_en, stop_check_en  output  1 each  one-cycle check strobes.
REQ-012 deser_en  output  1  one-cycle strobe that shifts the sampled bit into the deserializer.
REQ-013 edge_cnt  output  6  current oversample edge within the bit.
REQ-014 bit_cnt  output  4  current bit index within the frame.
REQ-015 data_valid  output  1  one-cycle pulse marking a good frame.
REQ-016 busy  output  1  high while a frame is in progress.

Function
REQ-017 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE SHALL move to START on the first clk edge that sees rx_in==0; edge_cnt=0 and bit_cnt=0 on the first START cycle.
REQ-019 prescale SHALL be latched on IDLE->START and held constant for the frame.
REQ-020 A latched prescale value other than 16 or 32 SHALL be treated as 8.
REQ-021 In every non-IDLE state, edge_cnt SHALL increment each cycle and wrap from P-1 to 0, where P is the latched prescale.
REQ-022 bit_cnt SHALL increment on each edge_cnt wrap.
REQ-023 data_samp_en SHALL be 1 in every non-IDLE state.
REQ-024 The check strobe for the current state SHALL fire for exactly one cycle at edge_cnt==P/2+2: start_check_en in START, deser_en in DATA, par_check_en in PARITY, stop_check_en in STOP.
REQ-025 At edge_cnt==P-1 in START: if start_glitch==1, go to IDLE; otherwise go to DATA.
REQ-026 At edge_cnt==P-1 in DATA with bit_cnt==DATA_WIDTH: go to PARITY if par_en==1, otherwise go to STOP.
REQ-027 At edge_cnt==P-1 in PARITY: go to STOP regardless of par_err.
REQ-028 At edge_cnt==P-1 in STOP: pulse data_valid on the next cycle iff stop_err==0 and (par_en==0 or par_err==0).
REQ-029 At edge_cnt==P-1 in STOP: go to START with counters zeroed if rx_in==0 (back-to-back frame); otherwise go to IDLE.
REQ-030 par_en SHALL be sampled once, when DATA is left; a change mid-frame SHALL have no effect on the current frame.
REQ-031 busy SHALL equal (state!=IDLE).
REQ-032 In IDLE, edge_cnt, bit_cnt and all strobes SHALL be 0.

Reset
REQ-033 While rst==0: state=IDLE; edge_cnt=0, bit_cnt=0 and all outputs 0.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no data_valid pulse.
REQ-035 After reset release, the block SHALL wait in IDLE for a falling edge on rx_in.

Structure
REQ-036 A shared package SHALL hold the state encoding typedef and the constants PRESCALE_8/16/32 and DATA_WIDTH.
REQ-037 The edge/bit counter SHALL be a sub-module named uart_rx_edge_bit_cnt, with inputs enable, clear and prescale.
REQ-038 The controller SHALL contain only the FSM and the output decode.

Verification
REQ-039 prescale=8, par_en=0, frame 0x5A with clean checker inputs -> deser_en fires 8 times at edge_cnt==6; data_valid pulses once, 10*8 cycles after the start-bit detect.
REQ-040 prescale=16, par_en=1, par_err=1 during PARITY -> STOP is entered, stop_check_en fires once, no data_valid.
REQ-041 rx_in low for 3 cycles then high, with start_glitch=1 -> return to IDLE at edge_cnt==7 of START; DATA never entered; busy low again.
REQ-042 Two frames back-to-back, rx_in=0 at the STOP end -> direct STOP->START with no IDLE cycle; two data_valid pulses.
REQ-043 rst asserted during DATA at bit_cnt==4 -> all outputs 0 immediately; no data_valid; the next frame is received correctly.
REQ-044 prescale=12 -> frame timed with P=8; prescale changed to 32 mid-frame -> no timing change until the next frame.
